// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Time-multiplexed driver for a bank of 7-segment digits. A packed hex value is
// captured into a pending register on load. At each frame boundary it is copied
// into the display register, which is then scanned one digit per PRESCALE-cycle slot.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading zero
// digits are darkened automatically; digit 0 always stays lit.
module hex_display_scanner #(
   parameter int DIGITS     = 4,
   parameter int PRESCALE   = 50000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   blank_mask,
   output logic [6:0]          seg_out,
   output logic [DIGITS-1:0]   dig_sel,
   output logic                frame_done
);

   localparam int                PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int                IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Hex nibble to active-high segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                slot_end;
   logic                frame_q, frame_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;
   logic [DIGITS-1:0]   lz_blank;
   logic [DIGITS-1:0]   dark;
   logic [3:0]          cur_nib;
   logic                cur_dark;

   // Slot and digit counters. frame_d anticipates the wrap so frame_done is a
   // clean register that is high exactly in the cycle whose closing edge wraps idx.
   always_comb begin
      slot_end  = (pre_cnt_q == PRE_LAST);
      pre_cnt_d = slot_end ? '0 : pre_cnt_q + PW'(1);
      idx_d     = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      frame_d = (pre_cnt_d == PRE_LAST) && (idx_d == IDX_LAST);
   end

   // Pending/display pairs. The display pair only changes at a frame boundary and
   // takes the post-load pending pair, so a load in the boundary cycle goes straight through.
   always_comb begin
      pend_val_d   = pend_val_q;
      pend_blank_d = pend_blank_q;
      disp_val_d   = disp_val_q;
      disp_blank_d = disp_blank_q;
      if (load) begin
         pend_val_d   = value;
         pend_blank_d = blank_mask;
      end
      if (frame_q) begin
         disp_val_d   = pend_val_d;
         disp_blank_d = pend_blank_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic upper_zero;

   // Digit i is a leading zero when it and every higher nibble are zero; digit 0 is exempt.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero  = upper_zero & (disp_val_q[4*i +: 4] == 4'h0);
         lz_blank[i] = upper_zero;
      end
   end
`else
   assign lz_blank = '0;
`endif

   assign dark = disp_blank_q | lz_blank;

   // Select the current digit, decode it, and apply pin polarity last.
   always_comb begin
      cur_nib  = 4'h0;
      cur_dark = 1'b1;
      dig_d    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib  = disp_val_q[4*i +: 4];
            cur_dark = dark[i];
            dig_d[i] = 1'b1;
         end
      end
      seg_d = cur_dark ? 7'h00 : hex_to_seg(cur_nib);
      if (ACTIVE_LOW != 0) begin
         seg_d = ~seg_d;
         dig_d = ~dig_d;
      end
   end

   // State registers; reset leaves the display blank and both output buses off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q    <= '0;
         idx_q        <= '0;
         frame_q      <= 1'b0;
         pend_val_q   <= '0;
         pend_blank_q <= '1;
         disp_val_q   <= '0;
         disp_blank_q <= '1;
         seg_q        <= SEG_OFF;
         dig_q        <= DIG_OFF;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         idx_q        <= idx_d;
         frame_q      <= frame_d;
         pend_val_q   <= pend_val_d;
         pend_blank_q <= pend_blank_d;
         disp_val_q   <= disp_val_d;
         disp_blank_q <= disp_blank_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
      end
   end

   assign seg_out    = seg_q;
   assign dig_sel    = dig_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner: two instances (active-high and active-low pins)
// share one stimulus stream and are checked against a cycle-count based model.
module tb_hex_display_scanner;

   localparam int D  = 4;
   localparam int P  = 2;
   localparam int DP = D * P;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   localparam logic [6:0] DEC_T [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        load       = 1'b0;
   logic [15:0] value      = 16'h0;
   logic [3:0]  blank_mask = 4'h0;
   logic [6:0]  seg0, seg1;
   logic [3:0]  dig0, dig1;
   logic        fd0, fd1;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   hex_display_scanner #(.DIGITS(D), .PRESCALE(P), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_mask(blank_mask),
      .seg_out(seg0), .dig_sel(dig0), .frame_done(fd0));

   hex_display_scanner #(.DIGITS(D), .PRESCALE(P), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_mask(blank_mask),
      .seg_out(seg1), .dig_sel(dig1), .frame_done(fd1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected active-high segments for digit k of a displayed value/blank pair.
   function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic [3:0] b, input int k);
      logic [15:0] upper;
      upper = v >> (4 * k);
      if (b[k]) return 7'h00;
      if (LZB && (k != 0) && (upper == 16'h0)) return 7'h00;
      return DEC_T[upper[3:0]];
   endfunction

   // Reference model: n counts rising edges since reset release; digit index and
   // frame position follow from n by arithmetic.
   int          n;
   logic [15:0] m_pv, m_dv;
   logic [3:0]  m_pb, m_db;
   logic [6:0]  e_seg;
   logic [3:0]  e_dig;
   logic        e_fd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n     <= 0;
         m_pv  <= 16'h0;
         m_dv  <= 16'h0;
         m_pb  <= 4'hF;
         m_db  <= 4'hF;
         e_seg <= 7'h00;
         e_dig <= 4'h0;
         e_fd  <= 1'b0;
      end else begin
         e_dig <= 4'(1 << ((n / P) % D));
         e_seg <= exp_seg(m_dv, m_db, (n / P) % D);
         if (load) begin
            m_pv <= value;
            m_pb <= blank_mask;
            if ((n % DP) == DP - 1) begin
               m_dv <= value;
               m_db <= blank_mask;
            end
         end else if ((n % DP) == DP - 1) begin
            m_dv <= m_pv;
            m_db <= m_pb;
         end
         e_fd <= ((n + 1) % DP) == DP - 1;
         n    <= n + 1;
      end
   end

   // Continuous comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("seg", seg0, e_seg);
         check("dig", dig0, e_dig);
         check("frame_done", fd0, e_fd);
         check("seg_al", seg1, {~e_seg});
         check("dig_al", dig1, {~e_dig});
         check("frame_done_al", fd1, e_fd);
      end
   end

   typedef struct {
      logic [15:0]     val;
      logic [3:0]      blank;
      logic [3:0][6:0] seg;
   } vec_t;

   vec_t tab [6];

   task automatic wait_fd();
      int k;
      for (k = 0; k < 4 * DP; k++) begin
         @(negedge clk);
         if (fd0 === 1'b1) break;
      end
      if (k == 4 * DP) begin
         checks++;
         failures++;
         $display("FAIL wait_frame_done actual=timeout required=pulse");
      end
   endtask

   // Waits for a boundary, then samples every digit slot of the following frame.
   task automatic capture_check(input string nm, input logic [3:0][6:0] exp);
      logic [3:0] dm;
      wait_fd();
      @(negedge clk);
      for (int k = 0; k < D; k++) begin
         @(negedge clk);
         dm = 4'(1 << k);
         check($sformatf("%s_seg%0d", nm, k), seg0, exp[k]);
         check($sformatf("%s_dig%0d", nm, k), dig0, dm);
         check($sformatf("%s_al_seg%0d", nm, k), seg1, {~exp[k]});
         check($sformatf("%s_al_dig%0d", nm, k), dig1, {~dm});
         repeat (P - 1) @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] b);
      load       = 1'b1;
      value      = v;
      blank_mask = b;
      @(negedge clk);
      load       = 1'b0;
   endtask

   initial begin
      logic [3:0] first_dig [8];
      int         k;
      first_dig = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};

      tab[0] = '{16'hF1A3, 4'b0000, {7'h71, 7'h06, 7'h77, 7'h4F}};
      tab[1] = '{16'h8888, 4'b0100, {7'h7F, 7'h00, 7'h7F, 7'h7F}};
      tab[2] = '{16'h0050, 4'b0000, LZB ? {7'h00, 7'h00, 7'h6D, 7'h3F} : {7'h3F, 7'h3F, 7'h6D, 7'h3F}};
      tab[3] = '{16'h0000, 4'b0000, LZB ? {7'h00, 7'h00, 7'h00, 7'h3F} : {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
      tab[4] = '{16'hD2B5, 4'b1001, {7'h00, 7'h5B, 7'h7C, 7'h00}};
      tab[5] = '{16'hC764, 4'b0000, {7'h39, 7'h07, 7'h7D, 7'h66}};

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      check("rst_seg", seg0, 7'h00);
      check("rst_dig", dig0, 4'h0);
      check("rst_fd", fd0, 1'b0);
      check("rst_al_seg", seg1, 7'h7F);
      check("rst_al_dig", dig1, 4'hF);

      // First frame after release: blank, one-hot walk, frame_done in its last cycle.
      rst_n  = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < DP; i++) begin
         @(negedge clk);
         check($sformatf("frame1_seg%0d", i), seg0, 7'h00);
         check($sformatf("frame1_dig%0d", i), dig0, first_dig[i]);
         check($sformatf("frame1_fd%0d", i), fd0, (i == DP - 2) ? 1'b1 : 1'b0);
      end

      // Mid-frame load stays hidden until the boundary.
      @(negedge clk);
      do_load(tab[0].val, tab[0].blank);
      check("pre_boundary_blank", seg0, 7'h00);
      capture_check("f1a3", tab[0].seg);

      // Load in the frame_done cycle shows from digit 0 of the very next frame.
      wait_fd();
      do_load(16'h0008, 4'h0);
      @(negedge clk);
      check("bnd_load_seg", seg0, 7'h7F);
      check("bnd_load_dig", dig0, 4'h1);

      // Two loads in one frame: the later one wins.
      @(negedge clk);
      do_load(16'h1111, 4'h0);
      do_load(16'h2222, 4'h0);
      capture_check("last_wins", {7'h5B, 7'h5B, 7'h5B, 7'h5B});

      // Table-driven patterns.
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         do_load(tab[i].val, tab[i].blank);
         capture_check($sformatf("vec%0d", i), tab[i].seg);
      end

      // Asynchronous reset during digit 2's slot.
      for (k = 0; k < 2 * DP; k++) begin
         @(negedge clk);
         if (dig0 === 4'b0100) break;
      end
      check("reach_digit2", dig0, 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_seg", seg0, 7'h00);
      check("async_rst_dig", dig0, 4'h0);
      check("async_rst_fd", fd0, 1'b0);
      check("async_rst_al_seg", seg1, 7'h7F);
      check("async_rst_al_dig", dig1, 4'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3 * DP; i++) begin
         @(negedge clk);
         check("post_rst_blank", seg0, 7'h00);
         if (i == 0) check("post_rst_dig0", dig0, 4'h1);
      end

      // Randomized loads, checked by the model.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         load       = ($urandom_range(0, 5) == 0);
         value      = 16'($urandom);
         blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      @(negedge clk);
      load = 1'b0;
      repeat (2 * DP) @(negedge clk);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits, replacing the single-digit combinational 3-bit decoder. It captures a packed multi-digit hex value and scans it one digit per refresh slot, with full 0–F decoding, per-digit blanking, a programmable scan rate and a frame-complete strobe. It sits between the datapath's display/debug register and the board's segment and digit-enable pins.

## Interface
- DIGITS, 4: number of digits scanned; range 1–8.
- PRESCALE, 50000: clk cycles each digit stays enabled; minimum 1.
- ACTIVE_LOW, 0: 1 inverts both seg_out and dig_sel, so a lit segment or enabled digit drives 0.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; captures value and blank_mask.
- value  input  4*DIGITS  packed nibbles; digit 0 is bits [3:0].
- blank_mask  input  DIGITS  bit i = 1 forces digit i dark.
- seg_out  output  7  segments, bit order gfedcba, registered.
- dig_sel  output  DIGITS  one-hot digit enable, registered.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Decode is gfedcba, in hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Registers:
  - pend_val and pend_blank form the pending pair; load writes it.
  - disp_val and disp_blank form the display pair; the scanner reads only this pair.
  - pre_cnt counts 0..PRESCALE-1.
  - idx counts 0..DIGITS-1.
- Scan: when pre_cnt = PRESCALE-1, pre_cnt returns to 0 and idx advances. idx wraps from DIGITS-1 to 0.
- Frame boundary is the cycle in which idx wraps. In that cycle:
  - frame_done is high.
  - The pending pair is copied into the display pair, so the display never tears mid-frame.
- load in the wrap cycle: the incoming value and blank_mask go straight into both the pending and display pairs. The new data therefore shows from digit 0 of the next frame.
- Repeated load within one frame: the last load before the boundary wins.
- Output for the current idx:
  - dig_sel has bit idx asserted.
  - seg_out is the decode of nibble idx, or all segments off if disp_blank[idx] = 1.
  - ACTIVE_LOW polarity is applied last.
- DIGITS = 1: idx stays 0, and frame_done pulses every PRESCALE cycles.
- Reset values (asynchronous, on rst_n low):
  - pre_cnt = 0, idx = 0.
  - pend_val and disp_val = 0; pend_blank and disp_blank = all ones.
  - seg_out = all off (0x00, or 0x7F if ACTIVE_LOW).
  - dig_sel = all off (0, or all ones if ACTIVE_LOW).
  - frame_done = 0.
- Reset mid-frame: all of the above apply immediately. Scanning restarts at digit 0 with the display blank until the first load has been copied at a frame boundary.

## Timing
- seg_out and dig_sel follow idx with exactly one cycle of register latency.
- Each digit slot is exactly PRESCALE cycles; a frame is DIGITS*PRESCALE cycles.
- After reset release, the first frame_done is at cycle DIGITS*PRESCALE (cycle 1 = first rising edge with rst_n high).
- A load is visible on seg_out no later than one frame plus one cycle after the next frame boundary.
- No ready/valid handshake: load is always accepted, never back-pressured, and ignored while rst_n is low.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: any digit whose nibble and all higher-index nibbles in disp_val are 0 is also blanked (ORed with disp_blank). Digit 0 is never auto-blanked, so value 0 shows "0".
  - Undefined: only blank_mask blanks digits.

## Test plan
- Reset, then release rst_n with DIGITS=4, PRESCALE=2, ACTIVE_LOW=0 -> seg_out=0x00 for the whole first frame; dig_sel sequence 0001,0010,0100,1000 at 2-cycle spacing; frame_done high at cycle 8.
- load value=0xF1A3, blank_mask=0 mid-frame -> no change until the boundary; next frame seg_out = 4F, 77, 06, 71 for digits 0..3.
- load asserted in the same cycle as frame_done, value=0x0008 -> digit 0 shows 7F in the immediately following frame. Second check: load 0x1111 then 0x2222 within one frame -> only 5B is displayed.
- blank_mask=4'b0100 with value 0x8888 -> digit 2 slot has seg_out=0x00 and dig_sel=0100. Repeat with ACTIVE_LOW=1 -> seg_out=0x7F, dig_sel=1011.
- LEADING_ZERO_BLANK_EN defined, value=0x0050 -> digits 3 and 2 dark, digit 1 = 6D, digit 0 = 3F. value=0x0000 -> only digit 0 lit, showing 3F.
- Assert rst_n low during digit 2's slot -> outputs go to the all-off reset values asynchronously; after release, scanning restarts at digit 0 and the display stays blank until a new load.
